bit_population_generator: RTL

Inverse of the bit population counter: accepts a requested population count and a candidate bit mask, and produces a WIDTH-bit word with that many ones. The ones are placed on the lowest-indexed set bits of the mask. Work is done serially, PIPE_SIZE bits per cycle, from LSB to MSB, so area stays bounded for wide words. Typical uses are building test vectors for the counter and generating thermometer or selection masks for arbitration logic.

---
 rtl/bit_population_generator.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bit_population_generator.sv
// Inverse popcount: places N ones on the lowest set bits of a mask, scanning
// PIPE_SIZE bits per cycle from LSB to MSB under a three-state handshake FSM.
module bit_population_generator #(
   parameter int WIDTH     = 16,
   parameter int PIPE_SIZE = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [$clog2(WIDTH):0] data_i,
   input  logic [WIDTH-1:0]       mask_i,
   input  logic                   data_val_i,
   output logic                   ready_o,
   output logic [WIDTH-1:0]       data_o,
   output logic [$clog2(WIDTH):0] rem_o,
   output logic                   data_val_o,
   input  logic                   data_rdy_i
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int SW = $clog2(PIPE_SIZE) + 1;
   localparam int C  = (WIDTH + PIPE_SIZE - 1) / PIPE_SIZE;
   localparam int IW = (C > 1) ? $clog2(C) : 1;
   localparam logic [IW-1:0] LAST = IW'(C - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic [IW-1:0]        r_idx;
   logic [WIDTH-1:0]     r_mask, r_word, r_data_o;
   logic [CW-1:0]        r_rem, r_rem_o;
   logic [PIPE_SIZE-1:0] w_cmask, w_set;
   logic [SW-1:0]        w_sum;
   logic [WIDTH-1:0]     w_word_nxt;
   logic [CW-1:0]        w_rem_nxt;
   logic                 w_last;

   assign w_last    = (r_idx == LAST);
   assign w_rem_nxt = r_rem - CW'(w_sum);
   assign data_o    = r_data_o;
   assign rem_o     = r_rem_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      data_val_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (data_val_i) w_state_nxt = S_BUSY;
         end
         S_BUSY: if (w_last) w_state_nxt = S_DONE;
         S_DONE: begin
            data_val_o = 1'b1;
            if (data_rdy_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Gather the current chunk; lanes past WIDTH in a partial last chunk stay 0.
   always_comb begin
      w_cmask = '0;
      for (int p = 0; p < WIDTH; p++)
         if (r_idx == IW'(p / PIPE_SIZE)) w_cmask[p % PIPE_SIZE] = r_mask[p];
   end

   // A lane fires while the ones already placed in this chunk are below r_rem,
   // so the subtraction below can never underflow.
   always_comb begin
      w_set = '0;
      w_sum = '0;
      for (int j = 0; j < PIPE_SIZE; j++) begin
         w_set[j] = w_cmask[j] && (CW'(w_sum) < r_rem);
         w_sum    = w_sum + SW'(w_set[j]);
      end
   end

   always_comb begin
      w_word_nxt = r_word;
      for (int p = 0; p < WIDTH; p++)
         if ((r_idx == IW'(p / PIPE_SIZE)) && w_set[p % PIPE_SIZE]) w_word_nxt[p] = 1'b1;
   end

   // Result registers are separate so data_o/rem_o persist across the next scan.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_idx    <= '0;
         r_mask   <= '0;
         r_word   <= '0;
         r_rem    <= '0;
         r_data_o <= '0;
         r_rem_o  <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (data_val_i) begin
               r_rem  <= data_i;
               r_mask <= mask_i;
               r_word <= '0;
               r_idx  <= '0;
            end
            S_BUSY: begin
               r_word <= w_word_nxt;
               r_rem  <= w_rem_nxt;
               if (w_last) begin
                  r_idx    <= '0;
                  r_data_o <= w_word_nxt;
                  r_rem_o  <= w_rem_nxt;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
